// File: rtl/seg_capture.sv
// Seven-segment read-back: scans eight active-low digit buses, decodes them to nibbles and
// publishes a frame once it has been stable for STABLE_FRAMES scans (valid held until ready).
module seg_capture #(
  parameter int STABLE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_seg0,
  input  logic [7:0]  i_seg1,
  input  logic [7:0]  i_seg2,
  input  logic [7:0]  i_seg3,
  input  logic [7:0]  i_seg4,
  input  logic [7:0]  i_seg5,
  input  logic [7:0]  i_seg6,
  input  logic [7:0]  i_seg7,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_value,
  output logic [7:0]  o_blank,
  output logic [7:0]  o_err
);

  localparam logic [3:0] SF = STABLE_FRAMES[3:0];

  // Returns {err, blank, nibble}; dp (bit 0) is ignored.
  function automatic logic [5:0] decode(input logic [7:0] seg);
    logic [6:0] p;
    p = ~seg[7:1];
    case (p)
      7'b1111110: decode = 6'h00;
      7'b0110000: decode = 6'h01;
      7'b1101101: decode = 6'h02;
      7'b1111001: decode = 6'h03;
      7'b0110011: decode = 6'h04;
      7'b1011011: decode = 6'h05;
      7'b1011111: decode = 6'h06;
      7'b1110000: decode = 6'h07;
      7'b1111111: decode = 6'h08;
      7'b1111011: decode = 6'h09;
      7'b1110111: decode = 6'h0A;
      7'b0011111: decode = 6'h0B;
      7'b1001110: decode = 6'h0C;
      7'b0111101: decode = 6'h0D;
      7'b1001111: decode = 6'h0E;
      7'b1000111: decode = 6'h0F;
      7'b0000000: decode = 6'b010000;
      default:    decode = 6'b100000;
    endcase
  endfunction

  logic [2:0]  idx;
  logic [31:0] sh_nib;
  logic [7:0]  sh_blank;
  logic [7:0]  sh_err;
  logic [47:0] last_frame;
  logic [47:0] pub_frame;
  logic        pubbed;
  logic [3:0]  cnt;

  logic [7:0]  cur_seg;
  logic [5:0]  cur_dec;
  logic [31:0] sh_nib_n;
  logic [7:0]  sh_blank_n;
  logic [7:0]  sh_err_n;
  logic [47:0] frame_n;
  logic        frame_end;
  logic [3:0]  cnt_n;
  logic        publish;

  always_comb begin
    cur_seg = i_seg0;
    case (idx)
      3'd0: cur_seg = i_seg0;
      3'd1: cur_seg = i_seg1;
      3'd2: cur_seg = i_seg2;
      3'd3: cur_seg = i_seg3;
      3'd4: cur_seg = i_seg4;
      3'd5: cur_seg = i_seg5;
      3'd6: cur_seg = i_seg6;
      default: cur_seg = i_seg7;
    endcase
  end

  assign cur_dec = decode(cur_seg);

  // The frame compared at frame end already contains digit 7 decoded this cycle.
  always_comb begin
    sh_nib_n        = sh_nib;
    sh_blank_n      = sh_blank;
    sh_err_n        = sh_err;
    sh_nib_n[idx*4 +: 4] = cur_dec[3:0];
    sh_blank_n[idx] = cur_dec[4];
    sh_err_n[idx]   = cur_dec[5];
  end

  assign frame_n   = {sh_err_n, sh_blank_n, sh_nib_n};
  assign frame_end = (idx == 3'd7);

  always_comb begin
    cnt_n = 4'd1;
    if (frame_n == last_frame)
      cnt_n = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
  end

  // o_valid gates publish, so a frame-end coinciding with acceptance waits one more frame.
  assign publish = frame_end && (cnt_n >= SF) && !o_valid &&
                   (!pubbed || (frame_n != pub_frame));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= 3'd0;
      sh_nib     <= '0;
      sh_blank   <= '0;
      sh_err     <= '0;
      last_frame <= '0;
      pub_frame  <= '0;
      pubbed     <= 1'b0;
      cnt        <= 4'd0;
      o_valid    <= 1'b0;
      o_value    <= '0;
      o_blank    <= '0;
      o_err      <= '0;
    end else begin
      idx      <= idx + 3'd1;
      sh_nib   <= sh_nib_n;
      sh_blank <= sh_blank_n;
      sh_err   <= sh_err_n;
      if (frame_end) begin
        last_frame <= frame_n;
        cnt        <= cnt_n;
      end
      if (o_valid && i_ready)
        o_valid <= 1'b0;
      if (publish) begin
        o_valid   <= 1'b1;
        o_value   <= frame_n[31:0];
        o_blank   <= frame_n[39:32];
        o_err     <= frame_n[47:40];
        pub_frame <= frame_n;
        pubbed    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed test-plan scenarios plus randomized traffic against a frame-level model.
module tb_seg_capture;
  localparam int SF = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg [8];
  logic        rdy;
  logic        o_valid;
  logic [31:0] o_value;
  logic [7:0]  o_blank;
  logic [7:0]  o_err;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int abscyc = 0;

  logic [6:0] pat [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // Frame-level model state
  int          m_pos;
  int          m_cnt;
  logic [3:0]  m_nib [8];
  logic        m_bl [8];
  logic        m_er [8];
  logic [47:0] m_last;
  logic [47:0] m_pubf;
  logic [47:0] m_out;
  bit          m_pubbed;
  bit          m_valid;

  seg_capture #(.STABLE_FRAMES(SF)) dut (
    .clk(clk), .rst(rst),
    .i_seg0(seg[0]), .i_seg1(seg[1]), .i_seg2(seg[2]), .i_seg3(seg[3]),
    .i_seg4(seg[4]), .i_seg5(seg[5]), .i_seg6(seg[6]), .i_seg7(seg[7]),
    .i_ready(rdy), .o_valid(o_valid), .o_value(o_value),
    .o_blank(o_blank), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v = 0..15 hex digit, 16 = blank; dp is the raw (active-high) dp bit before inversion
  function automatic logic [7:0] enc(input int v, input bit dp);
    logic [6:0] p;
    p = (v < 16) ? pat[v] : 7'b0;
    return ~{p, dp};
  endfunction

  function automatic logic [47:0] pack_frame();
    logic [47:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f[4*k +: 4] = m_nib[k];
      f[32 + k]   = m_bl[k];
      f[40 + k]   = m_er[k];
    end
    return f;
  endfunction

  task automatic model_step();
    logic [6:0] p;
    bit found, pubnow, v_before;
    logic [47:0] f;
    if (rst) begin
      m_pos = 0; m_cnt = 0; m_last = '0; m_pubf = '0; m_out = '0;
      m_pubbed = 0; m_valid = 0;
      for (int k = 0; k < 8; k++) begin m_nib[k] = 0; m_bl[k] = 0; m_er[k] = 0; end
    end else begin
      p = ~seg[m_pos][7:1];
      found = 0;
      m_nib[m_pos] = 0;
      for (int v = 0; v < 16; v++)
        if (pat[v] == p) begin m_nib[m_pos] = 4'(v); found = 1; end
      m_bl[m_pos] = (p == 7'b0);
      m_er[m_pos] = !found && (p != 7'b0);
      pubnow = 0;
      v_before = m_valid;
      if (m_pos == 7) begin
        f = pack_frame();
        if (f == m_last) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else begin m_last = f; m_cnt = 1; end
        pubnow = (m_cnt >= SF) && !v_before && (!m_pubbed || m_last != m_pubf);
      end
      if (v_before && rdy) m_valid = 0;
      if (pubnow) begin
        m_valid = 1; m_out = m_last; m_pubf = m_last; m_pubbed = 1;
      end
      m_pos = (m_pos + 1) % 8;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (rst) ncyc = 0; else ncyc++;
    abscyc++;
    #1;
    check("valid", o_valid, m_valid);
    check("outputs", {o_err, o_blank, o_value}, m_out);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    abscyc = 0;
    check("rst_valid", o_valid, 0);
    check("rst_outputs", {o_err, o_blank, o_value}, 48'h0);
  endtask

  task automatic wait_valid(input int maxc);
    for (int i = 0; i < maxc && !o_valid; i++) tick();
  endtask

  task automatic set_digits_k();
    for (int k = 0; k < 8; k++) seg[k] = enc(k, 0);
  endtask

  initial begin
    int seen, start, r;
    rst = 1'b1;
    rdy = 1'b0;
    set_digits_k();

    // Digits 0..7 constant, ready low
    do_reset();
    wait_valid(64);
    check("t1_rise", ncyc, 32);
    check("t1_value", o_value, 32'h76543210);
    check("t1_blank", o_blank, 8'h00);
    check("t1_err", o_err, 8'h00);
    repeat (20) tick();
    check("t1_hold_valid", o_valid, 1);
    check("t1_hold_value", o_value, 32'h76543210);

    // Accept, then no republish of the identical frame
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    check("t2_fall", o_valid, 0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (o_valid) seen = 1; end
    check("t2_quiet", seen, 0);

    // Blank and invalid digits
    for (int k = 0; k < 8; k++) seg[k] = enc(10, 0);
    seg[3] = 8'hFF;
    seg[5] = ~8'b0000_0010;
    do_reset();
    wait_valid(64);
    check("t3_rise", ncyc, 32);
    check("t3_value", o_value, 32'hAA0A0AAA);
    check("t3_blank", o_blank, 8'h08);
    check("t3_err", o_err, 8'h20);

    // Digit 0 toggling 1/2 every 16 cycles never stabilises
    set_digits_k();
    do_reset();
    seen = 0;
    for (int i = 0; i < 128; i++) begin
      seg[0] = enc(((i / 16) % 2) ? 2 : 1, 0);
      tick();
      if (o_valid) seen = 1;
    end
    check("t4_no_valid", seen, 0);
    seg[0] = enc(2, 0);
    start = ncyc;
    wait_valid(8 * (SF + 1));
    check("t4_pub", o_valid, 1);
    check("t4_in_time", (ncyc - start) <= 8 * (SF + 1), 1);
    check("t4_value", o_value, 32'h76543212);

    // Reset in the middle of stabilisation
    set_digits_k();
    do_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (o_valid) seen = 1; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_valid(80);
    check("t5_early", seen, 0);
    check("t5_rise", abscyc, 53);

    // dp toggling must not disturb stability
    for (int k = 0; k < 8; k++) seg[k] = enc(15, 0);
    do_reset();
    for (int i = 0; i < 64 && !o_valid; i++) begin
      for (int k = 0; k < 8; k++) seg[k] = enc(15, ncyc % 2);
      tick();
    end
    check("t6_rise", ncyc, 32);
    check("t6_value", o_value, 32'hFFFFFFFF);
    check("t6_err", o_err, 8'h00);

    // Randomized traffic checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < 8; k++) begin
          r = $urandom_range(0, 19);
          seg[k] = (r <= 16) ? enc(r, $urandom_range(0, 1)) : 8'($urandom);
        end
      end else if ($urandom_range(0, 99) == 0) begin
        seg[$urandom_range(0, 7)] = enc($urandom_range(0, 16), 0);
      end
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 3) == 0) seg[k][0] = ~seg[k][0];
      rdy = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
